// File: rtl/io_timer_core.sv
// Compare timer on one slot of the IO controller register bus: W-bit up-counter with prescaler,
// compare match, optional auto-reload, sticky match flag and level interrupt.
module io_timer_core #(
  parameter int unsigned W     = 48,
  parameter int unsigned PRESC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int unsigned HW         = W - 32;
  localparam logic [15:0] PRESC_LAST = 16'(PRESC - 1);

  typedef enum logic [4:0] {
    A_CTRL   = 5'd0,
    A_CNT_LO = 5'd1,
    A_CNT_HI = 5'd2,
    A_CMP_LO = 5'd3,
    A_CMP_HI = 5'd4,
    A_STATUS = 5'd5
  } reg_addr_e;

  reg_addr_e reg_sel;

  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  cmp_q, cmp_d;
  logic [15:0]   presc_cnt_q, presc_cnt_d;
  logic [HW-1:0] shadow_hi_q, shadow_hi_d;
  logic          go_q, go_d;
  logic          auto_reload_q, auto_reload_d;
  logic          irq_en_q, irq_en_d;
  logic          match_flag_q, match_flag_d;

  logic wr_en, rd_en, wr_ctrl, clr_pulse, tick, hit, match;

  assign reg_sel   = reg_addr_e'(addr);
  assign wr_en     = cs & write;
  assign rd_en     = cs & read;
  assign wr_ctrl   = wr_en && (reg_sel == A_CTRL);
  assign clr_pulse = wr_ctrl & wr_data[1];
  assign tick      = go_q && (presc_cnt_q == PRESC_LAST);
  assign hit       = (count_q == cmp_q);
  // A clear pulse owns the counter for its edge, so a coincident compare hit is dropped.
  assign match     = tick && hit && !clr_pulse;

  always_comb begin
    count_d       = count_q;
    cmp_d         = cmp_q;
    presc_cnt_d   = presc_cnt_q;
    shadow_hi_d   = shadow_hi_q;
    go_d          = go_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    match_flag_d  = match_flag_q;

    if (clr_pulse || tick) begin
      presc_cnt_d = '0;
    end else if (go_q) begin
      presc_cnt_d = presc_cnt_q + 16'd1;
    end

    if (clr_pulse) begin
      count_d = '0;
    end else if (tick && hit && auto_reload_q) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + W'(1);
    end

    if (wr_ctrl) begin
      go_d          = wr_data[0];
      auto_reload_d = wr_data[2];
      irq_en_d      = wr_data[3];
    end

    if (wr_en && (reg_sel == A_CMP_LO)) begin
      cmp_d[31:0] = wr_data;
    end
    if (wr_en && (reg_sel == A_CMP_HI)) begin
      cmp_d[W-1:32] = wr_data[HW-1:0];
    end

    // Set is evaluated last so a match wins over a simultaneous W1C.
    if (wr_en && (reg_sel == A_STATUS) && wr_data[0]) begin
      match_flag_d = 1'b0;
    end
    if (match) begin
      match_flag_d = 1'b1;
    end

    if (rd_en && (reg_sel == A_CNT_LO)) begin
      shadow_hi_d = count_q[W-1:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q       <= '0;
      cmp_q         <= '1;
      presc_cnt_q   <= '0;
      shadow_hi_q   <= '0;
      go_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      match_flag_q  <= 1'b0;
    end else begin
      count_q       <= count_d;
      cmp_q         <= cmp_d;
      presc_cnt_q   <= presc_cnt_d;
      shadow_hi_q   <= shadow_hi_d;
      go_q          <= go_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      match_flag_q  <= match_flag_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      A_CTRL:   rd_data[3:0]    = {irq_en_q, auto_reload_q, 1'b0, go_q};
      A_CNT_LO: rd_data         = count_q[31:0];
      A_CNT_HI: rd_data[HW-1:0] = shadow_hi_q;
      A_CMP_LO: rd_data         = cmp_q[31:0];
      A_CMP_HI: rd_data[HW-1:0] = cmp_q[W-1:32];
      A_STATUS: rd_data[0]      = match_flag_q;
      default:  rd_data         = '0;
    endcase
  end

  assign irq = match_flag_q & irq_en_q;

endmodule

// File: tb/tb_io_timer_core.sv
// Scoreboard bench for io_timer_core: three instances (W=48/PRESC=1, W=33, PRESC=4) on a shared bus.
module tb_io_timer_core;

  localparam int M = 0;
  localparam int S = 1;
  localparam int P = 2;
  localparam int NONE = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  cs = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_w [3];
  logic        irq_w [3];

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  io_timer_core #(.W(48), .PRESC(1)) dut (
    .clk(clk), .reset(reset), .cs(cs[0]), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_w[0]), .irq(irq_w[0])
  );

  io_timer_core #(.W(33), .PRESC(1)) dut33 (
    .clk(clk), .reset(reset), .cs(cs[1]), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_w[1]), .irq(irq_w[1])
  );

  io_timer_core #(.W(48), .PRESC(4)) dut_p4 (
    .clk(clk), .reset(reset), .cs(cs[2]), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_w[2]), .irq(irq_w[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One bus cycle spanning exactly one rising edge; read data sampled before that edge.
  task automatic xfer(input int sel, input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input string tag);
    cs = '0;
    if (sel < 3) cs[sel] = 1'b1;
    read    = r;
    write   = w;
    addr    = a;
    wr_data = d;
    if (r) exp_q.push_back(exp);
    #2;
    if (r) check_eq(tag, rd_w[sel % 3], exp_q.pop_front());
    @(negedge clk);
    cs    = '0;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input int sel, input logic [4:0] a, input logic [31:0] d);
    xfer(sel, 1'b0, 1'b1, a, d, '0, "");
  endtask

  task automatic rd(input int sel, input logic [4:0] a, input logic [31:0] exp, input string tag);
    xfer(sel, 1'b1, 1'b0, a, '0, exp, tag);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    exp_q.push_back({31'b0, exp});
    check_eq(tag, {31'b0, irq_w[0]}, exp_q.pop_front());
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset defaults
    reset = 1'b0;
    cycles(3);
    reset = 1'b1;
    rd(M, 5'd0, 32'h0, "rst_ctrl");
    rd(M, 5'd1, 32'h0, "rst_cnt_lo");
    rd(M, 5'd2, 32'h0, "rst_cnt_hi");
    rd(M, 5'd3, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(M, 5'd4, 32'h0000_FFFF, "rst_cmp_hi");
    rd(M, 5'd5, 32'h0, "rst_status");
    rd(M, 5'd6, 32'h0, "rst_addr6");
    rd(M, 5'd31, 32'h0, "rst_addr31");
    rd(S, 5'd4, 32'h0000_0001, "rst_cmp_hi33");
    chk_irq(1'b0, "rst_irq");

    // Free run with PRESC=1: ten ticks between go and stop
    wr(M, 5'd0, 32'h1);
    cycles(9);
    wr(M, 5'd0, 32'h0);
    rd(M, 5'd1, 32'd10, "run10");
    cycles(5);
    rd(M, 5'd1, 32'd10, "hold10");
    rd(M, 5'd0, 32'h0, "ctrl_stopped");

    // Read+write same cycle shows pre-write value; write without cs ignored
    xfer(M, 1'b1, 1'b1, 5'd3, 32'h0000_1234, 32'hFFFF_FFFF, "rdwr_pre");
    rd(M, 5'd3, 32'h0000_1234, "rdwr_post");
    xfer(NONE, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0, "");
    rd(M, 5'd3, 32'h0000_1234, "cs0_wr");
    wr(M, 5'd1, 32'hDEAD_BEEF);
    rd(M, 5'd1, 32'd10, "ro_wr_ignored");

    // Compare + auto-reload + irq, period 6
    wr(M, 5'd4, 32'h0);
    wr(M, 5'd3, 32'd5);
    wr(M, 5'd0, 32'hF);
    rd(M, 5'd0, 32'h0000_000D, "ctrl_rb");
    cycles(4);
    chk_irq(1'b0, "irq_pre");
    cycles(1);
    chk_irq(1'b1, "irq_match");
    rd(M, 5'd1, 32'd0, "reload");
    rd(M, 5'd5, 32'h1, "flag_set");
    wr(M, 5'd5, 32'h1);
    chk_irq(1'b0, "irq_w1c");
    cycles(2);
    chk_irq(1'b0, "irq_pre2");
    wr(M, 5'd5, 32'h1);
    chk_irq(1'b1, "set_beats_w1c");
    rd(M, 5'd1, 32'd0, "period6");
    wr(M, 5'd0, 32'h0);
    chk_irq(1'b0, "irq_en_off");
    rd(M, 5'd5, 32'h1, "flag_kept");
    wr(M, 5'd5, 32'h0);
    rd(M, 5'd5, 32'h1, "w1c_zero");
    wr(M, 5'd5, 32'h1);
    rd(M, 5'd5, 32'h0, "w1c_one");
    rd(M, 5'd1, 32'd2, "held_after_stop");

    // Coherent LO/HI across the 32-bit carry, compare at 2^32
    wr(M, 5'd3, 32'h0);
    wr(M, 5'd4, 32'h1);
    wr(M, 5'd0, 32'h3);
    force dut.count_q = 48'h0000_FFFF_FFFD;
    #1;
    release dut.count_q;
    rd(M, 5'd1, 32'hFFFF_FFFD, "lo_a");
    rd(M, 5'd2, 32'h0, "hi_a");
    rd(M, 5'd1, 32'hFFFF_FFFF, "lo_b");
    rd(M, 5'd2, 32'h0, "hi_b_coherent");
    rd(M, 5'd1, 32'h0000_0001, "lo_c");
    rd(M, 5'd2, 32'h0000_0001, "hi_c_carry");
    rd(M, 5'd5, 32'h1, "cmp_2p32");
    wr(M, 5'd0, 32'h0);

    // W=33 wrap without compare hit
    wr(S, 5'd3, 32'd5);
    wr(S, 5'd4, 32'h0);
    wr(S, 5'd0, 32'h3);
    force dut33.count_q = 33'h1_FFFF_FFFE;
    #1;
    release dut33.count_q;
    rd(S, 5'd1, 32'hFFFF_FFFE, "w33_lo_a");
    rd(S, 5'd1, 32'hFFFF_FFFF, "w33_lo_max");
    rd(S, 5'd2, 32'h0000_0001, "w33_hi_max");
    rd(S, 5'd1, 32'h0000_0001, "w33_wrapped");
    rd(S, 5'd5, 32'h0, "w33_noflag");
    rd(S, 5'd2, 32'h0, "w33_hi_wrapped");
    wr(S, 5'd0, 32'h0);

    // Clear pulse while running
    wr(M, 5'd0, 32'h3);
    cycles(4);
    rd(M, 5'd1, 32'd4, "pre_clr");
    wr(M, 5'd0, 32'h3);
    rd(M, 5'd1, 32'd0, "clr_run");
    cycles(2);
    rd(M, 5'd1, 32'd3, "after_clr");

    // Reset mid-run
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    rd(M, 5'd0, 32'h0, "mid_rst_ctrl");
    rd(M, 5'd1, 32'h0, "mid_rst_cnt");
    rd(M, 5'd3, 32'hFFFF_FFFF, "mid_rst_cmp");
    rd(M, 5'd5, 32'h0, "mid_rst_status");
    chk_irq(1'b0, "mid_rst_irq");

    // PRESC=4
    wr(P, 5'd0, 32'h1);
    cycles(7);
    rd(P, 5'd1, 32'd1, "p4_one");
    cycles(3);
    rd(P, 5'd1, 32'd2, "p4_two");
    cycles(3);
    rd(P, 5'd1, 32'd3, "p4_three");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
